// File: rtl/pn_spike_encoder_if.sv
// -----------------------------------------------------------------------------
// pn_spike_encoder_if
// Packet stream from the spike encoder towards the neighbouring PN controller.
//   o_valid : packet valid (encoder -> consumer)
//   o_ready : consumer accepts the packet (consumer -> encoder)
//   o_ADDR  : 16-bit packet address word
//   o_DATA  : 32-bit packet data word
// modport master : the encoder side, drives valid/address/data
// modport slave  : the consumer side, drives ready
// -----------------------------------------------------------------------------
interface pn_spike_encoder_if;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_ADDR;
    logic [31:0] o_DATA;

    modport master (
        output o_valid,
        output o_ADDR,
        output o_DATA,
        input  o_ready
    );

    modport slave (
        input  o_valid,
        input  o_ADDR,
        input  o_DATA,
        output o_ready
    );
endinterface

// File: rtl/pn_spike_encoder.sv
// -----------------------------------------------------------------------------
// pn_spike_encoder
// Turns one timestep's fire vector into a stream of address/data spike packets.
// Ordinary neurons are paired two per packet (lower ID in the first slot),
// rich-club neurons are sent alone with the rich-club flag set.
//
// Ports:
//   clk        : core clock, rising edge
//   rst        : asynchronous active-low reset
//   kill       : synchronous abort, clears everything except the timestep counter
//   fire_valid : end-of-timestep pulse, fire_vec sampled with it
//   fire_vec   : fired neurons (bit i = neuron i)
//   rc_mask    : rich-club neurons (stable while o_busy is high)
//   pkt        : packet stream (o_valid/o_ready/o_ADDR/o_DATA), master side
//   o_busy     : high whenever the FSM is not idle
//   o_overrun  : sticky, a fire vector arrived while busy and was dropped
//
// Configuration macro: PN_ENC_TSTAMP_EN
//   defined   : a TS_WIDTH timestep counter is built and carried in o_DATA
//   undefined : no counter, o_DATA is constant zero
// -----------------------------------------------------------------------------
module pn_spike_encoder #(
    parameter int NUM_NEURON = 128,
    parameter int TS_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kill,
    input  logic                  fire_valid,
    input  logic [NUM_NEURON-1:0] fire_vec,
    input  logic [NUM_NEURON-1:0] rc_mask,
    pn_spike_encoder_if.master    pkt,
    output logic                  o_busy,
    output logic                  o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PICK = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_NEURON-1:0]   pending_q, pending_d;
    logic                    held_vld_q, held_vld_d;
    logic [6:0]              held_id_q, held_id_d;
    logic                    o_valid_q, o_valid_d;
    logic [15:0]             o_addr_q, o_addr_d;
    logic                    o_overrun_q, o_overrun_d;

    // Lowest set bit of pending: its ID, its one-hot position and its rich-club bit.
    logic [6:0]              ffs_id;
    logic [NUM_NEURON-1:0]   ffs_oh;
    logic                    ffs_rc;
    logic                    pending_any;
    logic                    accept_vec;
    logic                    pick_emit;

    always_comb begin
        ffs_id = 7'd0;
        ffs_oh = '0;
        ffs_rc = 1'b0;
        // Walking downwards leaves the lowest set bit as the final winner.
        for (int i = NUM_NEURON - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                ffs_id    = 7'(i);
                ffs_oh    = '0;
                ffs_oh[i] = 1'b1;
                ffs_rc    = rc_mask[i];
            end
        end
    end

    assign pending_any = |pending_q;
    assign accept_vec  = (state_q == S_IDLE) && fire_valid && (|fire_vec);

    // A PICK cycle produces a packet unless it only parks an ordinary neuron
    // as the held partner, or finds nothing left at all.
    assign pick_emit = (state_q == S_PICK) &&
                       (pending_any ? (ffs_rc || held_vld_q) : held_vld_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (accept_vec) state_d = S_PICK;
                S_PICK: begin
                    if (pick_emit)         state_d = S_EMIT;
                    else if (!pending_any) state_d = S_IDLE;
                end
                S_EMIT: if (pkt.o_ready) state_d = S_PICK;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        pending_d   = pending_q;
        held_vld_d  = held_vld_q;
        held_id_d   = held_id_q;
        o_valid_d   = o_valid_q;
        o_addr_d    = o_addr_q;
        o_overrun_d = o_overrun_q;

        // Busy includes the cycle in which the FSM is about to return to idle.
        if (fire_valid && (state_q != S_IDLE)) begin
            o_overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept_vec) pending_d = fire_vec;
            end
            S_PICK: begin
                if (!pending_any) begin
                    if (held_vld_q) begin
                        o_addr_d   = {2'b00, 7'd0, held_id_q};
                        o_valid_d  = 1'b1;
                        held_vld_d = 1'b0;
                    end
                end else if (ffs_rc) begin
                    o_valid_d = 1'b1;
                    if (held_vld_q) begin
                        // Flush the waiting partner first; the rich-club
                        // neuron stays pending for the next PICK.
                        o_addr_d   = {2'b00, 7'd0, held_id_q};
                        held_vld_d = 1'b0;
                    end else begin
                        o_addr_d  = {2'b01, 7'd0, ffs_id};
                        pending_d = pending_q & ~ffs_oh;
                    end
                end else if (held_vld_q) begin
                    o_addr_d   = {2'b00, ffs_id, held_id_q};
                    o_valid_d  = 1'b1;
                    held_vld_d = 1'b0;
                    pending_d  = pending_q & ~ffs_oh;
                end else begin
                    held_id_d  = ffs_id;
                    held_vld_d = 1'b1;
                    pending_d  = pending_q & ~ffs_oh;
                end
            end
            S_EMIT: begin
                if (pkt.o_ready) o_valid_d = 1'b0;
            end
            default: ;
        endcase

        if (kill) begin
            pending_d   = '0;
            held_vld_d  = 1'b0;
            held_id_d   = 7'd0;
            o_valid_d   = 1'b0;
            o_addr_d    = 16'd0;
            o_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q   <= '0;
            held_vld_q  <= 1'b0;
            held_id_q   <= 7'd0;
            o_valid_q   <= 1'b0;
            o_addr_q    <= 16'd0;
            o_overrun_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            held_vld_q  <= held_vld_d;
            held_id_q   <= held_id_d;
            o_valid_q   <= o_valid_d;
            o_addr_q    <= o_addr_d;
            o_overrun_q <= o_overrun_d;
        end
    end

`ifdef PN_ENC_TSTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
    logic [TS_WIDTH-1:0] ts_lat_q, ts_lat_d;
    logic [31:0]         o_data_q, o_data_d;

    always_comb begin
        ts_cnt_d = ts_cnt_q;
        ts_lat_d = ts_lat_q;
        o_data_d = o_data_q;
        // Every pulse advances the timestep, whether accepted, empty or dropped.
        if (fire_valid && !kill) ts_cnt_d = ts_cnt_q + TS_WIDTH'(1);
        // The vector's packets carry the timestep value current at its arrival.
        if (accept_vec)          ts_lat_d = ts_cnt_q;
        if (pick_emit)           o_data_d = 32'(ts_lat_q);
        if (kill) begin
            ts_lat_d = '0;
            o_data_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt_q <= '0;
            ts_lat_q <= '0;
            o_data_q <= 32'd0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_lat_q <= ts_lat_d;
            o_data_q <= o_data_d;
        end
    end

    assign pkt.o_DATA = o_data_q;
`else
    // Zero of timestamp width, zero-extended to the data word.
    assign pkt.o_DATA = 32'(TS_WIDTH'(0));
`endif

    assign pkt.o_valid = o_valid_q;
    assign pkt.o_ADDR  = o_addr_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_overrun   = o_overrun_q;

endmodule

// File: tb/tb_pn_spike_encoder.sv
module tb_pn_spike_encoder;
    localparam int N    = 128;
    localparam int TS_W = 16;

    logic         clk;
    logic         rst_n;
    logic         kill;
    logic         fire_valid;
    logic [N-1:0] fire_vec;
    logic [N-1:0] rc_mask;
    logic         o_busy;
    logic         o_overrun;

    pn_spike_encoder_if pkt_if();

    pn_spike_encoder #(.NUM_NEURON(N), .TS_WIDTH(TS_W)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .kill       (kill),
        .fire_valid (fire_valid),
        .fire_vec   (fire_vec),
        .rc_mask    (rc_mask),
        .pkt        (pkt_if.master),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          ts_model;
    bit          rand_ready;
    logic [47:0] exp_q[$];
    logic [47:0] got_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk the fired IDs upward, pair ordinary neurons, send
    // rich-club neurons alone after flushing any waiting partner.
    task automatic model_packets(input logic [N-1:0] vec, input logic [N-1:0] rc, input int ts);
        int          held;
        logic [31:0] d;
        held = -1;
`ifdef PN_ENC_TSTAMP_EN
        d = ts % (1 << TS_W);
`else
        d = 32'd0;
`endif
        for (int id = 0; id < N; id++) begin
            if (vec[id]) begin
                if (rc[id]) begin
                    if (held >= 0) exp_q.push_back({16'(held), d});
                    held = -1;
                    exp_q.push_back({16'h4000 | 16'(id), d});
                end else if (held < 0) begin
                    held = id;
                end else begin
                    exp_q.push_back({16'((id << 7) | held), d});
                    held = -1;
                end
            end
        end
        if (held >= 0) exp_q.push_back({16'(held), d});
    endtask

    function automatic logic [N-1:0] bits4(input int a, input int b, input int c, input int e);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (e >= 0) v[e] = 1'b1;
        return v;
    endfunction

    // One clock: log the handshake completing at the coming edge, advance to
    // #1 after it, then check hold-while-stalled and the post-accept gap.
    task automatic step();
        bit          accepted;
        bit          stalled;
        logic [15:0] s_addr;
        logic [31:0] s_data;
        accepted = rst_n && !kill && pkt_if.o_valid && pkt_if.o_ready;
        stalled  = rst_n && !kill && pkt_if.o_valid && !pkt_if.o_ready;
        s_addr   = pkt_if.o_ADDR;
        s_data   = pkt_if.o_DATA;
        if (accepted) begin
            got_q.push_back({pkt_if.o_ADDR, pkt_if.o_DATA});
            $display("packet addr=%h data=%h t=%0t", pkt_if.o_ADDR, pkt_if.o_DATA, $time);
        end
        @(posedge clk);
        #1;
        if (stalled) begin
            check("stall_valid", pkt_if.o_valid, 1'b1);
            check("stall_addr", pkt_if.o_ADDR, s_addr);
            check("stall_data", pkt_if.o_DATA, s_data);
        end
        if (accepted) check("gap_after_accept", pkt_if.o_valid, 1'b0);
        if (rand_ready) pkt_if.o_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse(input logic [N-1:0] vec, input bit accept);
        fire_vec   = vec;
        fire_valid = 1'b1;
        if (accept && vec != '0) model_packets(vec, rc_mask, ts_model);
        ts_model++;
        step();
        fire_valid = 1'b0;
        fire_vec   = '0;
    endtask

    task automatic wait_idle(input int exp_first, input int exp_len, input int stall);
        int first_c;
        int end_c;
        int stall_left;
        first_c    = -1;
        end_c      = -1;
        stall_left = stall;
        for (int c = 1; c <= 3000; c++) begin
            if (pkt_if.o_valid && stall > 0) begin
                if (stall_left > 0) stall_left--;
                else pkt_if.o_ready = 1'b1;
            end
            step();
            if (first_c < 0 && pkt_if.o_valid) first_c = c;
            if (!o_busy) begin
                end_c = c;
                break;
            end
        end
        check("idle_reached", end_c >= 0, 1'b1);
        if (exp_first >= 0) check("first_valid_cycle", first_c, exp_first);
        if (exp_len >= 0)   check("busy_cycles", end_c, exp_len);
    endtask

    task automatic compare_pkts(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), got_q[i][47:32], exp_q[i][47:32]);
            check($sformatf("%s_data%0d", name, i), got_q[i][31:0], exp_q[i][31:0]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run_vec(input string name, input logic [N-1:0] vec, input logic [N-1:0] rc,
                           input int exp_first, input int exp_len, input int stall);
        rc_mask = rc;
        pulse(vec, 1'b1);
        check({name, "_busy_rise"}, o_busy, vec != '0);
        wait_idle(exp_first, exp_len, stall);
        compare_pkts(name);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!pkt_if.o_valid && k < 20) begin
            step();
            k++;
        end
        check({name, "_valid_seen"}, pkt_if.o_valid, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] r;
        n_checks       = 0;
        n_errors       = 0;
        ts_model       = 0;
        rand_ready     = 1'b0;
        rst_n          = 1'b0;
        kill           = 1'b0;
        fire_valid     = 1'b0;
        fire_vec       = '0;
        rc_mask        = '0;
        pkt_if.o_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", pkt_if.o_valid, 1'b0);
        check("rst_addr", pkt_if.o_ADDR, 16'h0);
        check("rst_data", pkt_if.o_DATA, 32'h0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_overrun", o_overrun, 1'b0);
        rst_n = 1'b1;
        step();

        // Pair {3,9}: valid two cycles after PICK entry, busy for 4 cycles.
        run_vec("pair_3_9", bits4(3, 9, -1, -1), '0, 2, 4, 0);

        // Zero vector: no packets, never busy, timestep still advances.
        pulse('0, 1'b1);
        check("zero_busy", o_busy, 1'b0);
        step();
        step();
        check("zero_busy_later", o_busy, 1'b0);
        compare_pkts("zero_vec");

        // Leading rich-club neuron 2, then single 4; third pulse carries ts 2.
        run_vec("rc2_single4", bits4(2, 4, -1, -1), bits4(2, -1, -1, -1), 1, -1, 0);

        // Four ordinary neurons: 3*4/2+1 cycles busy.
        run_vec("four_pairs", bits4(10, 20, 30, 127), '0, 2, 7, 0);

        // Back-pressure for 10 cycles on the first packet.
        pkt_if.o_ready = 1'b0;
        run_vec("stall", bits4(1, 6, 40, -1), bits4(40, -1, -1, -1), -1, -1, 10);
        pkt_if.o_ready = 1'b1;

        // Pulse on the very edge where busy falls is dropped.
        check("overrun_before", o_overrun, 1'b0);
        rc_mask = '0;
        pulse(bits4(3, 9, -1, -1), 1'b1);
        step();
        step();
        step();
        pulse(bits4(50, 51, -1, -1), 1'b0);
        check("edge_drop_busy", o_busy, 1'b0);
        check("edge_drop_overrun", o_overrun, 1'b1);
        step();
        step();
        check("edge_drop_idle", o_busy, 1'b0);
        compare_pkts("edge_drop");

        // Pulse mid-vector is dropped, no extra packets.
        pulse(bits4(1, 2, 3, 4), 1'b1);
        step();
        pulse(bits4(60, 61, 62, -1), 1'b0);
        wait_idle(-1, -1, 0);
        check("mid_drop_overrun", o_overrun, 1'b1);
        compare_pkts("mid_drop");

        // Counter kept advancing through the dropped pulses.
        run_vec("after_drop", bits4(7, 8, -1, -1), '0, 2, 4, 0);

        // Kill mid-handshake.
        pkt_if.o_ready = 1'b0;
        pulse(bits4(5, 6, -1, -1), 1'b1);
        wait_valid("kill");
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("kill_valid", pkt_if.o_valid, 1'b0);
        check("kill_busy", o_busy, 1'b0);
        check("kill_overrun", o_overrun, 1'b0);
        check("kill_addr", pkt_if.o_ADDR, 16'h0);
        check("kill_no_transfer", got_q.size(), 0);
        exp_q.delete();
        got_q.delete();
        pkt_if.o_ready = 1'b1;
        run_vec("after_kill", bits4(0, 127, -1, -1), bits4(127, -1, -1, -1), -1, -1, 0);

        // Randomized vectors with random back-pressure.
        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 9) == 0);
                r[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 7) == 0) v = '0;
            run_vec($sformatf("rand%0d", it), v, r, -1, -1, 0);
        end
        rand_ready     = 1'b0;
        pkt_if.o_ready = 1'b1;

        // Asynchronous reset in the middle of EMIT, away from any edge.
        pkt_if.o_ready = 1'b0;
        rc_mask        = '0;
        pulse(bits4(3, 9, -1, -1), 1'b1);
        pulse(bits4(11, -1, -1, -1), 1'b0);
        wait_valid("arst");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", pkt_if.o_valid, 1'b0);
        check("arst_addr", pkt_if.o_ADDR, 16'h0);
        check("arst_data", pkt_if.o_DATA, 32'h0);
        check("arst_busy", o_busy, 1'b0);
        check("arst_overrun", o_overrun, 1'b0);
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        ts_model       = 0;
        pkt_if.o_ready = 1'b1;
        step();
        run_vec("after_arst", bits4(3, 9, -1, -1), '0, 2, 4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
